writeback_unit: RTL and testbench

//  Producer side of the register-bank write port: merges ALU and load results into
//  the single we/ain/din stream, registered one cycle. ALU has fixed priority; load

---
 rtl/riscy_pkg.sv | 20 ++
 rtl/wb_load_fifo.sv | 62 ++++++
 rtl/wb_waw_check.sv | 16 +
 rtl/writeback_unit.sv | 160 ++++++++++++++++
 tb/tb_writeback_unit.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/riscy_pkg.sv
// Shared definitions for the writeback path: widths, the x0 address, the
// registered write-source tag and the load-queue entry layout.
package riscy_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LD   = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } ld_entry_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Load-result queue: DEPTH entries of {rd, data}. Pointers wrap naturally
// because DEPTH is a power of two; a pop frees its slot only from the next cycle.
module wb_load_fifo
  import riscy_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  ld_entry_t push_entry,
  input  logic      pop,
  output ld_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ld_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == {CW{1'b0}});
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care while not counted as occupied.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

endmodule

// File: rtl/wb_waw_check.sv
// Simulation checker: an ALU write to a register still awaiting its load
// result is a pipeline bug upstream; the datapath writes anyway.
module wb_waw_check
  import riscy_pkg::*;
(
  input logic                  clock,
  input logic                  reset,
  input logic                  alu_valid,
  input logic [REG_ADDR_W-1:0] alu_rd,
  input logic [31:0]           busy
);

  waw_hazard: assert property (@(posedge clock) disable iff (reset)
    !(alu_valid && (alu_rd != REG_ZERO) && busy[alu_rd]));

endmodule

// File: rtl/writeback_unit.sv
// Merges ALU and load results onto the registered we/ain/din write port and
// resolves issue operands/stall. Define WB_FORWARDING_EN to bypass instead of stall.
module writeback_unit
  import riscy_pkg::*;
#(
  parameter int LDQ_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]       ld_data,
  input  logic                  iss_ld_valid,
  input  logic [REG_ADDR_W-1:0] iss_ld_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [XLEN-1:0]       rf_rs1_val,
  input  logic [XLEN-1:0]       rf_rs2_val,
  output logic [XLEN-1:0]       op1,
  output logic [XLEN-1:0]       op2,
  output logic                  stall,
  output logic                  we,
  output logic [REG_ADDR_W-1:0] ain,
  output logic [XLEN-1:0]       din
);

  wb_src_e               wb_src;
  wb_src_e               sel_src;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;
  logic [31:0]           busy;
  logic [31:0]           busy_next;
  logic                  alu_sel;
  logic                  ld_take;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  ld_entry_t             push_entry;
  ld_entry_t             head;
  logic                  haz1;
  logic                  haz2;

  wb_load_fifo #(.DEPTH(LDQ_DEPTH)) u_ldq (
    .clock      (clock),
    .reset      (reset),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  wb_waw_check u_waw (
    .clock     (clock),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .busy      (busy)
  );

  assign ld_ready        = !fifo_full;
  assign alu_sel         = alu_valid && (alu_rd != REG_ZERO);
  assign ld_take         = ld_valid && ld_ready && (ld_rd != REG_ZERO);
  assign push_entry.rd   = ld_rd;
  assign push_entry.data = ld_data;
  assign we              = (wb_src != WB_NONE);

  // Write-port arbitration: ALU first, then queued loads, then a fresh load
  // straight through when nothing is queued (keeps idle-path load latency at one cycle).
  always_comb begin
    sel_src   = WB_NONE;
    sel_rd    = REG_ZERO;
    sel_data  = {XLEN{1'b0}};
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    if (alu_sel) begin
      sel_src   = WB_ALU;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
      fifo_push = ld_take;
    end else if (!fifo_empty) begin
      sel_src   = WB_LD;
      sel_rd    = head.rd;
      sel_data  = head.data;
      fifo_pop  = 1'b1;
      fifo_push = ld_take;
    end else if (ld_take) begin
      sel_src   = WB_LD;
      sel_rd    = ld_rd;
      sel_data  = ld_data;
    end else begin
      fifo_push = 1'b0;
    end
  end

  // Scoreboard update: clear on load-sourced write, then set so a same-cycle set wins.
  always_comb begin
    busy_next = busy;
    if (sel_src == WB_LD) begin
      busy_next[sel_rd] = 1'b0;
    end else begin
      busy_next = busy;
    end
    if (iss_ld_valid && (iss_ld_rd != REG_ZERO)) begin
      busy_next[iss_ld_rd] = 1'b1;
    end else begin
      busy_next[0] = 1'b0;
    end
    busy_next[0] = 1'b0;
  end

  // Registered write port and scoreboard.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_src <= WB_NONE;
      ain    <= REG_ZERO;
      din    <= {XLEN{1'b0}};
      busy   <= 32'd0;
    end else begin
      wb_src <= sel_src;
      ain    <= sel_rd;
      din    <= sel_data;
      busy   <= busy_next;
    end
  end

  // Operand resolution and hazard detection; x0 always reads as zero and never stalls.
  always_comb begin
    op1  = {XLEN{1'b0}};
    op2  = {XLEN{1'b0}};
    haz1 = busy[rs1];
    haz2 = busy[rs2];
`ifdef WB_FORWARDING_EN
    if (rs1 == REG_ZERO)                      op1 = {XLEN{1'b0}};
    else if (alu_valid && (alu_rd == rs1))    op1 = alu_data;
    else if (we && (ain == rs1))              op1 = din;
    else                                      op1 = rf_rs1_val;
    if (rs2 == REG_ZERO)                      op2 = {XLEN{1'b0}};
    else if (alu_valid && (alu_rd == rs2))    op2 = alu_data;
    else if (we && (ain == rs2))              op2 = din;
    else                                      op2 = rf_rs2_val;
`else
    if (rs1 == REG_ZERO) op1 = {XLEN{1'b0}};
    else                 op1 = rf_rs1_val;
    if (rs2 == REG_ZERO) op2 = {XLEN{1'b0}};
    else                 op2 = rf_rs2_val;
    haz1 = busy[rs1] || (alu_valid && (alu_rd == rs1)) || (we && (ain == rs1));
    haz2 = busy[rs2] || (alu_valid && (alu_rd == rs2)) || (we && (ain == rs2));
`endif
  end

  assign stall = ((rs1 != REG_ZERO) && haz1) || ((rs2 != REG_ZERO) && haz2);

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios then random traffic,
// all compared against a queue/array reference model of the write-port rules.
module tb_writeback_unit;
  import riscy_pkg::*;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid, ld_valid, iss_ld_valid;
  logic [4:0]  alu_rd, ld_rd, iss_ld_rd, rs1, rs2;
  logic [31:0] alu_data, ld_data, rf_rs1_val, rf_rs2_val;
  logic        ld_ready, stall, we;
  logic [4:0]  ain;
  logic [31:0] op1, op2, din;

  writeback_unit #(.LDQ_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .iss_ld_valid(iss_ld_valid), .iss_ld_rd(iss_ld_rd),
    .rs1(rs1), .rs2(rs2), .rf_rs1_val(rf_rs1_val), .rf_rs2_val(rf_rs2_val),
    .op1(op1), .op2(op2), .stall(stall),
    .we(we), .ain(ain), .din(din)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [36:0] q[$];
  bit          busy_m[32];
  logic        m_we;
  logic [4:0]  m_ain;
  logic [31:0] m_din;
  bit          acc;
  int          idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_op(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 5'd0) return 32'd0;
`ifdef WB_FORWARDING_EN
    if (alu_valid && alu_rd == rs) return alu_data;
    if (m_we && m_ain == rs) return m_din;
`endif
    return rf;
  endfunction

  function automatic bit exp_hz(input logic [4:0] rs);
    if (rs == 5'd0) return 1'b0;
`ifndef WB_FORWARDING_EN
    if (alu_valid && alu_rd == rs) return 1'b1;
    if (m_we && m_ain == rs) return 1'b1;
`endif
    return busy_m[rs];
  endfunction

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0;
    iss_ld_valid = 1'b0; iss_ld_rd = 5'd0;
    rs1 = 5'd0; rs2 = 5'd0; rf_rs1_val = 32'd0; rf_rs2_val = 32'd0;
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
    m_we = 1'b0; m_ain = 5'd0; m_din = 32'd0;
  endtask

  // One cycle: check combinational outputs, advance the model, check the write port.
  task automatic step(output bit accepted);
    logic [36:0] e;
    bit          rdy;
    #1;
    rdy = (q.size() < DEPTH);
    check("ld_ready", {31'd0, ld_ready}, {31'd0, rdy});
    check("op1", op1, exp_op(rs1, rf_rs1_val));
    check("op2", op2, exp_op(rs2, rf_rs2_val));
    check("stall", {31'd0, stall}, {31'd0, exp_hz(rs1) || exp_hz(rs2)});
    accepted = ld_valid && rdy;
    if (accepted && ld_rd != 5'd0) q.push_back({ld_rd, ld_data});
    m_we = 1'b0; m_ain = 5'd0; m_din = 32'd0;
    if (alu_valid && alu_rd != 5'd0) begin
      m_we = 1'b1; m_ain = alu_rd; m_din = alu_data;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_we = 1'b1; m_ain = e[36:32]; m_din = e[31:0];
      busy_m[e[36:32]] = 1'b0;
    end
    if (iss_ld_valid && iss_ld_rd != 5'd0) busy_m[iss_ld_rd] = 1'b1;
    @(posedge clock);
    #1;
    check("we", {31'd0, we}, {31'd0, m_we});
    check("ain", {27'd0, ain}, {27'd0, m_ain});
    check("din", din, m_din);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_din", din, 32'd0);
    check("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    reset = 1'b0;

    // ALU only: result appears on the write port one edge later.
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF;
    step(acc);
    check("alu_we", {31'd0, we}, 32'd1);
    check("alu_ain", {27'd0, ain}, 32'd3);
    check("alu_din", din, 32'hDEADBEEF);

    // Bypass: ALU rd=9 feeding rs2 in the same cycle.
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h55;
    rs2 = 5'd9; rf_rs2_val = 32'h1234;
    #1;
`ifdef WB_FORWARDING_EN
    check("byp_op2", op2, 32'h55);
    check("byp_stall", {31'd0, stall}, 32'd0);
`else
    check("byp_op2", op2, 32'h1234);
    check("byp_stall", {31'd0, stall}, 32'd1);
`endif
    step(acc);

    // x0 destinations are dropped; rs=0 reads zero.
    idle_inputs();
    alu_valid = 1'b1; alu_data = 32'h77; ld_valid = 1'b1; ld_data = 32'h88;
    rf_rs1_val = 32'hFFFFFFFF;
    step(acc);
    check("x0_we", {31'd0, we}, 32'd0);
    idle_inputs();
    step(acc);

    // Scoreboard: load to x7 stalls rs1=7 until its write; rs1=0 never stalls.
    iss_ld_valid = 1'b1; iss_ld_rd = 5'd7;
    step(acc);
    idle_inputs();
    #1;
    check("sb_x0_stall", {31'd0, stall}, 32'd0);
    rs1 = 5'd7; rf_rs1_val = 32'hA5A5;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("sb_stall", {31'd0, stall}, 32'd1);
      step(acc);
    end
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h7777;
    step(acc);
    check("sb_ld_direct", din, 32'h7777);
    ld_valid = 1'b0;
    step(acc);
    step(acc);
    #1;
    check("sb_cleared", {31'd0, stall}, 32'd0);

    // Contention: ALU writes 4 cycles while 3 loads are offered.
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      iss_ld_valid = 1'b1; iss_ld_rd = 5'(20 + i);
      step(acc);
    end
    idle_inputs();
    rs1 = 5'd20; rs2 = 5'd22;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      alu_valid = (c < 4); alu_rd = 5'(10 + c); alu_data = 32'(c * 3 + 1);
      ld_valid = (idx < 3); ld_rd = 5'(20 + idx); ld_data = 32'(100 + idx);
      if (c == 2) begin
        #1;
        check("cont_full", {31'd0, ld_ready}, 32'd0);
      end
      step(acc);
      if (acc) idx++;
    end
    check("cont_all_accepted", idx, 3);

    // Reset mid-stream with two loads queued and x5 busy.
    idle_inputs();
    iss_ld_valid = 1'b1; iss_ld_rd = 5'd5;
    for (int c = 0; c < 2; c++) begin
      alu_valid = 1'b1; alu_rd = 5'(11 + c); alu_data = 32'(c);
      ld_valid = 1'b1; ld_rd = 5'(24 + c); ld_data = 32'(200 + c);
      step(acc);
      iss_ld_valid = 1'b0;
    end
    idle_inputs();
    rs1 = 5'd5;
    reset = 1'b1;
    model_reset();
    #1;
    check("mid_rst_we", {31'd0, we}, 32'd0);
    check("mid_rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) step(acc);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      alu_valid = ($urandom_range(0, 2) == 0);
      alu_rd = 5'($urandom_range(0, 31));
      if (busy_m[alu_rd]) alu_rd = 5'd0;
      alu_data = $urandom;
      ld_valid = ($urandom_range(0, 1) == 1);
      ld_rd = 5'($urandom_range(0, 31));
      ld_data = $urandom;
      iss_ld_valid = ($urandom_range(0, 3) == 0);
      iss_ld_rd = 5'($urandom_range(0, 31));
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      rf_rs1_val = $urandom;
      rf_rs2_val = $urandom;
      step(acc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
